// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment output path: FSM encoding, blank
// pattern, reference clock rate and the counter-width helper.
package seg7_pkg;

   localparam int CLK_HZ = 10_000_000;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_GAP  = 2'd1;
   localparam state_t ST_SHOW = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'b0;

   // Width of a counter that runs 0..terminal-1; never narrower than one bit.
   function automatic int cnt_width(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/seg7_pwm_blink.sv
// Free-running PWM counter and blink divider; produces the two gating terms a
// display output needs, independent of what is being displayed.
module seg7_pwm_blink
   import seg7_pkg::*;
#(
   parameter int PWM_BITS   = 3,
   parameter int BLINK_HALF = CLK_HZ / 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   output logic                pwm_on,
   output logic                blink_on
);

   localparam int             BW         = cnt_width(BLINK_HALF);
   localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [BW-1:0]       blink_cnt;
   logic                blink_phase;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Blink runs regardless of blink_en so enabling it lands on a stable cadence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BW'(1);
      end
   end

   assign pwm_on   = (pwm_cnt <= brightness);
   assign blink_on = !blink_en || blink_phase;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Output conditioning between the seg7 decoder and the pins: latch each new
// pattern, blank for a gap so repeated letters stay distinct, then show it
// gated by PWM brightness and blink, with the decimal point on the last char.
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int GAP_CYCLES = CLK_HZ / 10,
   parameter int BLINK_HALF = CLK_HZ / 4,
   parameter int PWM_BITS   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          seg_in,
   input  logic                seg_valid,
   input  logic                last_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   output logic [6:0]          seg_out,
   output logic                dp_out,
   output logic                busy
);

   localparam int            GW         = cnt_width(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam state_t        LOAD_STATE = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;

   state_t        state;
   state_t        next_state;
   logic [6:0]    hold_seg;
   logic          hold_last;
   logic [GW-1:0] gap_cnt;
   logic          gap_done;
   logic          pwm_on;
   logic          blink_on;
   logic          lit;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;
   logic          busy_nxt;

   seg7_pwm_blink #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_HALF (BLINK_HALF)
   ) u_pwm_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .brightness (brightness),
      .blink_en   (blink_en),
      .pwm_on     (pwm_on),
      .blink_on   (blink_on)
   );

   assign gap_done = (gap_cnt == GAP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (seg_valid) begin
         next_state = LOAD_STATE;
      end else begin
         case (state)
            ST_IDLE: next_state = ST_IDLE;
            ST_GAP:  if (gap_done) next_state = ST_SHOW;
            ST_SHOW: next_state = ST_SHOW;
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // NOTE: the hold registers are reset explicitly so a pattern from before
   // reset can never reappear; output resumes only with a fresh seg_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_seg  <= SEG_BLANK;
         hold_last <= 1'b0;
         gap_cnt   <= '0;
      end else if (seg_valid) begin
         hold_seg  <= seg_in;
         hold_last <= last_in;
         gap_cnt   <= '0;
      end else if (state == ST_GAP && !gap_done) begin
         gap_cnt   <= gap_cnt + GW'(1);
      end
   end

   // A character arriving mid-gap simply restarts the gap above; the
   // overwritten pattern is never displayed.
   always_comb begin
      lit      = (state == ST_SHOW) && pwm_on && blink_on;
      seg_nxt  = lit ? hold_seg : SEG_BLANK;
      dp_nxt   = lit && hold_last;
      busy_nxt = (next_state == ST_GAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out <= SEG_BLANK;
         dp_out  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         seg_out <= seg_nxt;
         dp_out  <= dp_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule
